// File: rtl/rst_seq_pkg.sv
// ============================================================================
//  Module      : rst_seq_pkg
//  Description : Shared definitions for the multi-channel reset sequencer.
//                Contains the sequencer state encoding, the width of the
//                SEQ_STATE debug port, and a clog2 helper used to size the
//                channel index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rst_seq_pkg;

    // Width of the SEQ_STATE debug port and of the state register
    localparam int unsigned SEQ_STATE_W = 2;

    // Sequencer states; the encoding is visible on SEQ_STATE
    typedef enum logic [SEQ_STATE_W-1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    // Ceiling log2 that never returns less than 1, so a single-channel
    // build still gets a legal one-bit index.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rst_sync2.sv
// ============================================================================
//  Module      : rst_sync2
//  Description : Two-flop synchroniser for a single asynchronous level.
//                Both flops clear to 0 on the asynchronous reset.
//  Ports       : clk  - destination clock
//                rst  - asynchronous active-high reset
//                i_d  - asynchronous input level
//                o_q  - synchronised output (2 clk latency)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
//  Module      : reset_sequencer
//  Description : Multi-channel reset sequencer. Waits for a filtered,
//                qualified PLL lock (PLL_LOCK and FAB_RESET_N, both
//                synchronised), then releases NUM_CH active-low resets in
//                order, STAGE_DELAY cycles apart, and raises INIT_DONE.
//                Supports per-channel soft resets in RUN and re-sequences
//                automatically on loss of qualified lock.
//  Macro       : RST_SEQ_WATCHDOG_EN - enables the lock watchdog that sets
//                LOCK_TIMEOUT after WDT_CYCLES cycles in WAIT_LOCK.
//  Ports       : CLK_BASE     - sole clock
//                RESET        - asynchronous active-high reset
//                PLL_LOCK     - asynchronous PLL lock (synchronised here)
//                FAB_RESET_N  - asynchronous active-low fabric reset request
//                SOFT_RESET   - per-channel soft reset, synchronous, RUN only
//                RESET_N_OUT  - sequenced active-low resets
//                INIT_DONE    - all channels released, in RUN
//                LOCK_LOST    - sticky, qualified lock lost after release began
//                LOCK_TIMEOUT - sticky watchdog flag (0 without watchdog)
//                SEQ_STATE    - current state, for debug
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned STAGE_DELAY = 256,
    parameter int unsigned LOCK_FILTER = 64,
    parameter int unsigned SOFT_HOLD   = 16,
    parameter int unsigned WDT_CYCLES  = 65535
) (
    input  logic                   CLK_BASE,
    input  logic                   RESET,
    input  logic                   PLL_LOCK,
    input  logic                   FAB_RESET_N,
    input  logic [NUM_CH-1:0]      SOFT_RESET,
    output logic [NUM_CH-1:0]      RESET_N_OUT,
    output logic                   INIT_DONE,
    output logic                   LOCK_LOST,
    output logic                   LOCK_TIMEOUT,
    output logic [SEQ_STATE_W-1:0] SEQ_STATE
);

    localparam int unsigned c_CH_W = clog2_min1(NUM_CH);

    localparam logic [SEQ_STATE_W-1:0] c_ST_HOLD      = HOLD;
    localparam logic [SEQ_STATE_W-1:0] c_ST_WAIT_LOCK = WAIT_LOCK;
    localparam logic [SEQ_STATE_W-1:0] c_ST_RELEASE   = RELEASE;
    localparam logic [SEQ_STATE_W-1:0] c_ST_RUN       = RUN;

    localparam logic [CNT_W-1:0]  c_FILT_LAST  = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0]  c_STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0]  c_SOFT_LAST  = CNT_W'(SOFT_HOLD);
    localparam logic [c_CH_W-1:0] c_CH_LAST    = c_CH_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] c_CH0_MASK   = NUM_CH'(1);
    localparam logic [63:0]       c_CNT_MAX    = (64'd1 << CNT_W) - 64'd1;

    // Reject configurations the counters cannot represent
    if ((NUM_CH < 1) || (NUM_CH > 16) || (STAGE_DELAY < 1) || (LOCK_FILTER < 1) ||
        (64'(STAGE_DELAY) > c_CNT_MAX) || (64'(LOCK_FILTER) > c_CNT_MAX) ||
        (64'(SOFT_HOLD) > c_CNT_MAX) || (64'(WDT_CYCLES) > c_CNT_MAX)) begin : g_bad_cfg
        $error("reset_sequencer: unsupported parameter combination");
    end

    // ------------------------------------------------------------------
    // Lock qualification
    // ------------------------------------------------------------------
    logic w_pll_lock_s;
    logic w_fab_rst_n_s;
    logic w_lock_q;

    rst_sync2 u_sync_pll (
        .clk (CLK_BASE),
        .rst (RESET),
        .i_d (PLL_LOCK),
        .o_q (w_pll_lock_s)
    );

    rst_sync2 u_sync_fab (
        .clk (CLK_BASE),
        .rst (RESET),
        .i_d (FAB_RESET_N),
        .o_q (w_fab_rst_n_s)
    );

    assign w_lock_q = w_pll_lock_s & w_fab_rst_n_s;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    logic [SEQ_STATE_W-1:0] r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [c_CH_W-1:0]      r_ch;
    logic [NUM_CH-1:0]      r_rst_n;
    logic                   r_init_done;
    logic                   r_lock_lost;

    logic                   w_run_ok;
    logic [NUM_CH-1:0]      w_soft_fire;
    logic [NUM_CH-1:0]      w_soft_done;
    logic                   w_wdt_expire;

    // Soft resets only act while in RUN with lock held; lock loss wins.
    assign w_run_ok = (r_state == c_ST_RUN) && w_lock_q;

    // ------------------------------------------------------------------
    // Per-channel soft-reset hold counters. A channel is busy from the
    // first sampled SOFT_RESET until SOFT_HOLD+1 edges after it falls.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_soft
        logic [CNT_W-1:0] r_soft_cnt;
        logic             r_soft_busy;

        always_ff @(posedge CLK_BASE or posedge RESET) begin
            if (RESET) begin
                r_soft_cnt  <= '0;
                r_soft_busy <= 1'b0;
            end else if (!w_run_ok) begin
                r_soft_cnt  <= '0;
                r_soft_busy <= 1'b0;
            end else if (SOFT_RESET[i]) begin
                r_soft_cnt  <= '0;
                r_soft_busy <= 1'b1;
            end else if (r_soft_busy) begin
                if (r_soft_cnt == c_SOFT_LAST) begin
                    r_soft_cnt  <= '0;
                    r_soft_busy <= 1'b0;
                end else begin
                    r_soft_cnt <= r_soft_cnt + CNT_W'(1);
                end
            end
        end

        assign w_soft_fire[i] = w_run_ok & SOFT_RESET[i];
        assign w_soft_done[i] = w_run_ok & r_soft_busy & ~SOFT_RESET[i] &
                                (r_soft_cnt == c_SOFT_LAST);
    end

    // ------------------------------------------------------------------
    // Main FSM. r_cnt is shared: lock filter in WAIT_LOCK, stage delay
    // in RELEASE.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_BASE or posedge RESET) begin
        if (RESET) begin
            r_state     <= c_ST_HOLD;
            r_cnt       <= '0;
            r_ch        <= '0;
            r_rst_n     <= '0;
            r_init_done <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            case (r_state)
                c_ST_HOLD: begin
                    r_state     <= c_ST_WAIT_LOCK;
                    r_cnt       <= '0;
                    r_ch        <= '0;
                    r_rst_n     <= '0;
                    r_init_done <= 1'b0;
                end

                c_ST_WAIT_LOCK: begin
                    if (w_wdt_expire || !w_lock_q) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_FILT_LAST) begin
                        r_state <= c_ST_RELEASE;
                        r_cnt   <= '0;
                        r_ch    <= '0;
                        r_rst_n <= c_CH0_MASK;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                c_ST_RELEASE: begin
                    if (!w_lock_q) begin
                        r_state     <= c_ST_WAIT_LOCK;
                        r_cnt       <= '0;
                        r_ch        <= '0;
                        r_rst_n     <= '0;
                        r_init_done <= 1'b0;
                        r_lock_lost <= 1'b1;
                    end else if (r_cnt == c_STAGE_LAST) begin
                        r_cnt <= '0;
                        if (r_ch == c_CH_LAST) begin
                            r_state     <= c_ST_RUN;
                            r_init_done <= 1'b1;
                        end else begin
                            r_ch    <= r_ch + c_CH_W'(1);
                            // Earlier channels stay released
                            r_rst_n <= r_rst_n | (c_CH0_MASK << (r_ch + c_CH_W'(1)));
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                c_ST_RUN: begin
                    if (!w_lock_q) begin
                        r_state     <= c_ST_WAIT_LOCK;
                        r_cnt       <= '0;
                        r_ch        <= '0;
                        r_rst_n     <= '0;
                        r_init_done <= 1'b0;
                        r_lock_lost <= 1'b1;
                    end else begin
                        // fire and done are mutually exclusive per channel
                        r_rst_n <= (r_rst_n & ~w_soft_fire) | w_soft_done;
                    end
                end

                default: begin
                    r_state <= c_ST_HOLD;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional lock watchdog
    // ------------------------------------------------------------------
`ifdef RST_SEQ_WATCHDOG_EN
    localparam logic [CNT_W-1:0] c_WDT_LAST = CNT_W'(WDT_CYCLES - 1);

    logic [CNT_W-1:0] r_wdt_cnt;
    logic             r_lock_timeout;

    assign w_wdt_expire = (r_state == c_ST_WAIT_LOCK) && (r_wdt_cnt == c_WDT_LAST);

    always_ff @(posedge CLK_BASE or posedge RESET) begin
        if (RESET) begin
            r_wdt_cnt      <= '0;
            r_lock_timeout <= 1'b0;
        end else if (r_state != c_ST_WAIT_LOCK) begin
            r_wdt_cnt <= '0;
        end else if (w_wdt_expire) begin
            r_wdt_cnt      <= '0;
            r_lock_timeout <= 1'b1;
        end else begin
            r_wdt_cnt <= r_wdt_cnt + CNT_W'(1);
        end
    end

    assign LOCK_TIMEOUT = r_lock_timeout;
`else
    assign w_wdt_expire = 1'b0;
    assign LOCK_TIMEOUT = 1'b0;
`endif

    assign RESET_N_OUT = r_rst_n;
    assign INIT_DONE   = r_init_done;
    assign LOCK_LOST   = r_lock_lost;
    assign SEQ_STATE   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
//  Module      : tb_reset_sequencer
//  Description : Directed self-checking bench for reset_sequencer with
//                NUM_CH=4, STAGE_DELAY=8, LOCK_FILTER=4, SOFT_HOLD=3,
//                WDT_CYCLES=20. Edge counts in comments are relative to the
//                most recent RESET release (E1 = first edge after release).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       fab_reset_n;
    logic [3:0] soft_reset;
    logic [3:0] reset_n_out;
    logic       init_done;
    logic       lock_lost;
    logic       lock_timeout;
    logic [1:0] seq_state;

    int vectors;
    int miscompares;

    reset_sequencer #(
        .NUM_CH      (4),
        .CNT_W       (16),
        .STAGE_DELAY (8),
        .LOCK_FILTER (4),
        .SOFT_HOLD   (3),
        .WDT_CYCLES  (20)
    ) u_dut (
        .CLK_BASE     (clk),
        .RESET        (rst),
        .PLL_LOCK     (pll_lock),
        .FAB_RESET_N  (fab_reset_n),
        .SOFT_RESET   (soft_reset),
        .RESET_N_OUT  (reset_n_out),
        .INIT_DONE    (init_done),
        .LOCK_LOST    (lock_lost),
        .LOCK_TIMEOUT (lock_timeout),
        .SEQ_STATE    (seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 ns after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hard time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL time_limit: observed still running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        pll_lock    = 1'b1;
        fab_reset_n = 1'b1;
        soft_reset  = 4'b0000;

        // ---------------- reset state ----------------
        tick(3);
        chk("rst_rstn",  32'(reset_n_out), 32'h0);
        chk("rst_done",  32'(init_done),   32'h0);
        chk("rst_lost",  32'(lock_lost),   32'h0);
        chk("rst_tmo",   32'(lock_timeout),32'h0);
        chk("rst_state", 32'(seq_state),   32'h0);

        // ---------------- power-up sequence ----------------
        rst = 1'b0;
        tick(1);                                  // E1: HOLD -> WAIT_LOCK
        chk("pu_wait_state", 32'(seq_state), 32'h1);
        tick(4);                                  // E5
        chk("pu_e5_rstn", 32'(reset_n_out), 32'h0);
        tick(1);                                  // E6: channel 0 released
        chk("pu_e6_rstn",  32'(reset_n_out), 32'h1);
        chk("pu_e6_state", 32'(seq_state),   32'h2);
        tick(7);                                  // E13
        chk("pu_e13_rstn", 32'(reset_n_out), 32'h1);
        tick(1);                                  // E14
        chk("pu_e14_rstn", 32'(reset_n_out), 32'h3);
        tick(8);                                  // E22
        chk("pu_e22_rstn", 32'(reset_n_out), 32'h7);
        tick(8);                                  // E30
        chk("pu_e30_rstn", 32'(reset_n_out), 32'hf);
        chk("pu_e30_done", 32'(init_done),   32'h0);
        tick(7);                                  // E37
        chk("pu_e37_done", 32'(init_done),   32'h0);
        tick(1);                                  // E38
        chk("pu_e38_done",  32'(init_done),  32'h1);
        chk("pu_e38_state", 32'(seq_state),  32'h3);
        chk("pu_e38_tmo",   32'(lock_timeout), 32'h0);

        // ---------------- soft reset on channel 2 ----------------
        soft_reset = 4'b0100;
        tick(1);                                  // S1
        chk("sr_s1_rstn", 32'(reset_n_out), 32'hb);
        tick(4);                                  // S5
        chk("sr_s5_rstn", 32'(reset_n_out), 32'hb);
        chk("sr_s5_done", 32'(init_done),   32'h1);
        soft_reset = 4'b0000;
        tick(3);                                  // S8
        chk("sr_s8_rstn", 32'(reset_n_out), 32'hb);
        tick(1);                                  // S9
        chk("sr_s9_rstn", 32'(reset_n_out), 32'hf);
        chk("sr_s9_done", 32'(init_done),   32'h1);

        // ---------------- lock loss in RUN ----------------
        pll_lock = 1'b0;
        tick(2);                                  // Y+2
        chk("ll_y2_rstn", 32'(reset_n_out), 32'hf);
        chk("ll_y2_lost", 32'(lock_lost),   32'h0);
        tick(1);                                  // Y+3
        chk("ll_y3_rstn",  32'(reset_n_out), 32'h0);
        chk("ll_y3_done",  32'(init_done),   32'h0);
        chk("ll_y3_lost",  32'(lock_lost),   32'h1);
        chk("ll_y3_state", 32'(seq_state),   32'h1);
        pll_lock = 1'b1;
        tick(5);                                  // Y+8
        chk("ll_y8_rstn", 32'(reset_n_out), 32'h0);
        tick(1);                                  // Y+9
        chk("ll_y9_rstn", 32'(reset_n_out), 32'h1);
        tick(31);                                 // Y+40
        chk("ll_y40_done", 32'(init_done), 32'h0);
        tick(1);                                  // Y+41
        chk("ll_y41_done", 32'(init_done),   32'h1);
        chk("ll_y41_rstn", 32'(reset_n_out), 32'hf);
        chk("ll_y41_lost", 32'(lock_lost),   32'h1);

        // ---------------- lock glitch during filtering ----------------
        rst = 1'b1;
        #2;
        chk("gl_rst_lost", 32'(lock_lost), 32'h0);
        rst = 1'b0;
        tick(2);                                  // E2
        pll_lock = 1'b0;
        tick(2);                                  // E4
        pll_lock = 1'b1;
        tick(2);                                  // E6: unglitched release point
        chk("gl_e6_rstn", 32'(reset_n_out), 32'h0);
        tick(3);                                  // E9
        chk("gl_e9_rstn", 32'(reset_n_out), 32'h0);
        tick(1);                                  // E10
        chk("gl_e10_rstn", 32'(reset_n_out), 32'h1);

        // soft reset outside RUN has no effect
        soft_reset = 4'b0001;
        tick(2);                                  // E12
        chk("gl_soft_ign", 32'(reset_n_out), 32'h1);
        soft_reset = 4'b0000;
        tick(14);                                 // E26: channel 2 released
        chk("gl_e26_rstn", 32'(reset_n_out), 32'h7);
        tick(2);                                  // E28, still ch=2

        // ---------------- RESET pulse during RELEASE ----------------
        rst = 1'b1;
        #1;
        chk("ar_rstn",  32'(reset_n_out), 32'h0);
        chk("ar_state", 32'(seq_state),   32'h0);
        chk("ar_done",  32'(init_done),   32'h0);
        rst = 1'b0;
        tick(1);                                  // E1
        chk("ar_e1_state", 32'(seq_state), 32'h1);
        tick(4);                                  // E5
        chk("ar_e5_rstn", 32'(reset_n_out), 32'h0);
        tick(1);                                  // E6
        chk("ar_e6_rstn", 32'(reset_n_out), 32'h1);
        tick(32);                                 // E38
        chk("ar_e38_done", 32'(init_done),   32'h1);
        chk("ar_e38_rstn", 32'(reset_n_out), 32'hf);

`ifdef RST_SEQ_WATCHDOG_EN
        // ---------------- lock watchdog ----------------
        pll_lock = 1'b0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick(20);                                 // E20
        chk("wd_e20_tmo", 32'(lock_timeout), 32'h0);
        tick(1);                                  // E21
        chk("wd_e21_tmo",   32'(lock_timeout), 32'h1);
        chk("wd_e21_state", 32'(seq_state),    32'h1);
        pll_lock = 1'b1;
        tick(5);                                  // E26
        chk("wd_e26_rstn", 32'(reset_n_out), 32'h0);
        tick(1);                                  // E27
        chk("wd_e27_rstn", 32'(reset_n_out), 32'h1);
        tick(32);                                 // E59
        chk("wd_e59_done", 32'(init_done),    32'h1);
        chk("wd_e59_tmo",  32'(lock_timeout), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
